// File: rtl/ssd_ctrl_pkg.sv
// Shared definitions for the SSD command register bank: word addresses of
// the host-visible registers, bit positions inside CTRL and IRQ_STAT, and the
// packed command record that travels through the command FIFO.
package ssd_ctrl_pkg;

  localparam logic [8:0] A_ID        = 9'h000;
  localparam logic [8:0] A_CTRL      = 9'h001;
  localparam logic [8:0] A_STATUS    = 9'h002;
  localparam logic [8:0] A_IRQ_STAT  = 9'h003;
  localparam logic [8:0] A_LBA       = 9'h004;
  localparam logic [8:0] A_LEN       = 9'h005;
  localparam logic [8:0] A_OP        = 9'h006;
  localparam logic [8:0] A_DOORBELL  = 9'h007;
  localparam logic [8:0] A_LAST_DONE = 9'h008;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CLR    = 2;

  localparam int IRQ_DONE = 0;
  localparam int IRQ_OVF  = 1;

  localparam int CMD_W = 60;

  typedef struct packed {
    logic [31:0] lba;
    logic [15:0] len;
    logic [7:0]  op;
    logic [3:0]  tag;
  } cmd_t;

endpackage

// File: rtl/ssd_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO: dout always shows the entry at the
// read pointer, so it is valid whenever empty is low.
// Ports: clk/rst (sync, active-high), push/din, pop, clr (wins over push/pop),
// dout, full, empty, count (AW+1 bits so a full FIFO is count == 2**AW).
// A push while full is taken only if a pop happens in the same cycle.
module ssd_cmd_fifo #(
  parameter int WIDTH = 60,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             clr,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [2**AW];
  logic [AW-1:0]    rptr, wptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(2**AW));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: it is never observed while empty.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wptr] <= din;
  end

endmodule

// File: rtl/ssd_cmd_regfile.sv
// Host register bank downstream of the Avalon slave export stage.
// Ports: clk, rst (sync, active-high); wr_n/rd_n/addr/wdata host strobes and
// registered rdata; cmd_* FIFO head toward the flash back end with
// cmd_valid/cmd_ready handshake; done_valid/done_tag/done_status completion
// pulse from the back end; irq level interrupt to the host.
// Commands staged in LBA/LEN/OP are pushed with the current tag on a doorbell
// write; completions latch into LAST_DONE and raise IRQ_STAT.done.
module ssd_cmd_regfile import ssd_ctrl_pkg::*; #(
  parameter logic [31:0] ID_VALUE = 32'h55D0_0001,
  parameter int          FIFO_AW  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_n,
  input  logic        rd_n,
  input  logic [8:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [31:0] cmd_lba,
  output logic [15:0] cmd_len,
  output logic [7:0]  cmd_op,
  output logic [3:0]  cmd_tag,
  input  logic        done_valid,
  input  logic [3:0]  done_tag,
  input  logic [7:0]  done_status,
  output logic        irq
);

  logic             wr, rd, wr_ctrl, wr_irq;
  logic             en, irq_en, clr_bit;
  logic [31:0]      lba;
  logic [15:0]      len;
  logic [7:0]       op;
  logic [3:0]       tag;
  logic             st_done, st_ovf;
  logic [11:0]      last_done;
  logic             full, empty, pop, push_req, accept, overflow, clr;
  logic [FIFO_AW:0] count;
  logic [31:0]      rmux;
  cmd_t             din, head;

  assign wr      = ~wr_n;
  assign rd      = ~rd_n;
  assign wr_ctrl = wr && (addr == A_CTRL);
  assign wr_irq  = wr && (addr == A_IRQ_STAT);

  // A full FIFO still accepts a doorbell when the head leaves in the same cycle.
  assign pop      = cmd_valid & cmd_ready;
  assign push_req = wr && (addr == A_DOORBELL) && en;
  assign accept   = push_req && (!full || pop);
  assign overflow = push_req && full && !pop;
  // Clear acts straight from the CTRL write so the FIFO is empty next cycle.
  assign clr      = wr_ctrl && wdata[CTRL_CLR];

  assign din = '{lba: lba, len: len, op: op, tag: tag};

  ssd_cmd_fifo #(.WIDTH(CMD_W), .AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .din   (din),
    .pop   (pop),
    .clr   (clr),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign cmd_valid = ~empty;
  assign cmd_lba   = head.lba;
  assign cmd_len   = head.len;
  assign cmd_op    = head.op;
  assign cmd_tag   = head.tag;

  always_comb begin
    rmux = '0;
    case (addr)
      A_ID:        rmux = ID_VALUE;
      A_CTRL:      rmux[2:0] = {clr_bit, irq_en, en};
      A_STATUS: begin
        rmux[0]           = full;
        rmux[1]           = empty;
        rmux[FIFO_AW+4:4] = count;
      end
      A_IRQ_STAT:  rmux[1:0] = {st_ovf, st_done};
      A_LBA:       rmux = lba;
      A_LEN:       rmux[15:0] = len;
      A_OP:        rmux[7:0] = op;
      A_LAST_DONE: rmux[11:0] = last_done;
      default:     rmux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en        <= 1'b0;
      irq_en    <= 1'b0;
      clr_bit   <= 1'b0;
      lba       <= '0;
      len       <= '0;
      op        <= '0;
      tag       <= '0;
      st_done   <= 1'b0;
      st_ovf    <= 1'b0;
      last_done <= '0;
      irq       <= 1'b0;
      rdata     <= '0;
    end else begin
      // fifo_clr reads back as 1 for one cycle only.
      clr_bit <= clr;
      if (wr_ctrl) begin
        en     <= wdata[CTRL_EN];
        irq_en <= wdata[CTRL_IRQ_EN];
      end
      if (wr && addr == A_LBA) lba <= wdata;
      if (wr && addr == A_LEN) len <= wdata[15:0];
      if (wr && addr == A_OP)  op  <= wdata[7:0];
      if (accept) tag <= tag + 4'd1;
      // Hardware set wins over a same-cycle write-1-to-clear.
      st_done <= done_valid | (st_done & ~(wr_irq & wdata[IRQ_DONE]));
      st_ovf  <= overflow   | (st_ovf  & ~(wr_irq & wdata[IRQ_OVF]));
      if (done_valid) last_done <= {done_tag, done_status};
      irq <= irq_en & (st_done | st_ovf);
      // Mux sees pre-write state, so a same-cycle read returns the old value.
      if (rd) rdata <= rmux;
    end
  end

endmodule
